uop_queue: RTL and testbench
============================

UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 SHALL: parameter DEPTH, default 8, entry count; power of two, minimum 4.
REQ-002 SHALL: parameter ENQ_W, default 2, enqueue lanes per cycle, 1..4.
REQ-003 SHALL: parameter DEQ_W, default 1, dequeue lanes per cycle, 1..4.
REQ-004 SHALL: parameter DATA_W, default $bits(liang_pkg::idToEx), payload width per entry.
REQ-005 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL: flush  input  1  discard all entries.
REQ-008 SHALL: enq_valid  input  ENQ_W  per-lane enqueue request.
REQ-009 SHALL: enq_data  input  ENQ_W*DATA_W  per-lane payload; lane i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL: enq_ready  output  1  queue accepts up to ENQ_W entries this cycle.
REQ-011 SHALL: deq_valid  output  DEQ_W  lane j holds a valid entry.
REQ-012 SHALL: deq_data  output  DEQ_W*DATA_W  lane j payload; same packing as enq_data.
REQ-013 SHALL: deq_ready  input  DEQ_W  consumer takes lane j.
REQ-014 SHALL: count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL: head and tail pointers use the flag+value form, value width $clog2(DEPTH), flag toggling on each wrap past DEPTH-1.
REQ-016 SHALL: empty when head equals tail in both flag and value; full when values are equal and flags differ.
REQ-017 SHALL: count equal (tail-head) computed over {flag,value}, range 0..DEPTH.
REQ-018 SHALL: enq_ready = (DEPTH-count >= ENQ_W), based only on registered state, never on same-cycle dequeue.
REQ-019 SHALL: enq_valid contiguous from lane 0; non-contiguous patterns are illegal (assertion), not handled.
REQ-020 SHALL: when enq_ready is high, write each valid lane i to slot tail+i (mod DEPTH) and advance tail by popcount(enq_valid).
REQ-021 SHALL: deq_valid[j] = (count > j); deq_data[j] = entry at head+j (mod DEPTH), combinational from registered storage.
REQ-022 SHALL: deq_ready contiguous from lane 0; head advances by number of lanes with deq_valid&deq_ready.
REQ-023 SHALL: ready on an invalid dequeue lane is ignored.
REQ-024 SHALL: enqueue and dequeue in the same cycle both take effect, with count updated by the net difference.
REQ-025 SHALL: latency from an accepted enqueue to deq_valid is exactly 1 cycle; no same-cycle bypass.
REQ-026 SHALL: order is strictly FIFO across lanes: lane 0 before lane 1, earlier cycles before later.
REQ-027 SHALL: flush high resets head and tail to {0,0} at the next edge, overriding same-cycle enqueue and dequeue.
REQ-028 SHALL: during the flush cycle outputs still reflect pre-flush state; count is 0 in the following cycle.

Reset
REQ-029 SHALL: rst_n low asynchronously sets head and tail to {0,0}; count=0, deq_valid=0, enq_ready=1.
REQ-030 SHALL: storage array not reset; deq_data is don't-care while deq_valid is low.
REQ-031 SHALL: reset mid-operation discards all entries; the first post-reset enqueue lands in slot 0.

Structure
REQ-032 SHALL: ptr_t generalised in utils to a parameterised flag+value pointer, together with shared helper functions ptr_add and ptr_diff.
REQ-033 SHALL: idToEx stays in liang_pkg as the default payload type.
REQ-034 SHALL: one sub-module, queue_ptr, holds a single flag+value pointer register with variable increment 0..4, instantiated for head and tail.

Verification (DEPTH=8, ENQ_W=2, DEQ_W=1)
REQ-035 SHALL: enqueue A,B in one cycle -> next cycle count=2, deq_data=A; dequeue -> B; second dequeue -> count=0, deq_valid=0.
REQ-036 SHALL: fill to count=6 -> enq_ready=1; fill to count=7 -> enq_ready=0 even with deq_ready=1 that cycle.
REQ-037 SHALL: push 20 sequential values (0..19) with random deq_ready -> output sequence 0..19 with no loss or duplication, and at least two wraps observed.
REQ-038 SHALL: at count=8 (full) -> full flag condition holds, enq_ready=0, deq_valid=1; one dequeue -> count=7, no enqueue since enq_ready=0.
REQ-039 SHALL: count=5 with enq and deq active and flush=1 -> next cycle count=0, deq_valid=0, enq_ready=1.
REQ-040 SHALL: rst_n low mid-stream at count=3 -> outputs immediately at reset values; after release, enqueue X -> deq_data=X.

Source files
------------

// File: rtl/liang_pkg.sv
// Decode-to-execute payload types shared across the core front end.
package liang_pkg;

    // Micro-op handed from decode to execute; default uop_queue payload.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [7:0]  imm;
        logic [1:0]  fu_sel;
    } idToEx;

endpackage

// File: rtl/utils.sv
// Shared helpers: flag+value ring pointers and small bit-count utilities.
package utils;

    // Widest pointer value field supported; narrower rings use the low bits.
    localparam int unsigned PTR_MAX_VW = 8;
    localparam int unsigned PTR_FULL_W = PTR_MAX_VW + 1;

    // Ring pointer: value indexes the slot, flag toggles on every wrap.
    typedef struct packed {
        logic                  flag;
        logic [PTR_MAX_VW-1:0] value;
    } ptr_t;

    // Collapse a pointer of value width vw into a (vw+1)-bit counter.
    function automatic logic [PTR_MAX_VW:0] ptr_flat(input ptr_t p, input int unsigned vw);
        logic [PTR_MAX_VW:0] vmask;
        vmask = (PTR_FULL_W'(1) << vw) - PTR_FULL_W'(1);
        return (PTR_FULL_W'(p.flag) << vw) | ({1'b0, p.value} & vmask);
    endfunction

    // Advance a pointer of value width vw by inc, toggling flag on wrap.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [2:0] inc, input int unsigned vw);
        logic [PTR_MAX_VW:0] sum;
        logic [PTR_MAX_VW:0] vmask;
        ptr_t                r;
        vmask   = (PTR_FULL_W'(1) << vw) - PTR_FULL_W'(1);
        sum     = ptr_flat(p, vw) + PTR_FULL_W'(inc);
        r.value = PTR_MAX_VW'(sum & vmask);
        r.flag  = |(sum & (PTR_FULL_W'(1) << vw));
        return r;
    endfunction

    // Distance a-b over {flag,value}; range 0..2**vw for a valid ring.
    function automatic logic [PTR_MAX_VW:0] ptr_diff(input ptr_t a, input ptr_t b, input int unsigned vw);
        logic [PTR_MAX_VW:0] fmask;
        fmask = (PTR_FULL_W'(2) << vw) - PTR_FULL_W'(1);
        return (ptr_flat(a, vw) - ptr_flat(b, vw)) & fmask;
    endfunction

    // Number of set bits in a lane mask of up to four lanes.
    function automatic logic [2:0] pop4(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/uop_queue_if.sv
// Producer/consumer bundle of the micro-op queue.
interface uop_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 1,
    parameter int unsigned DATA_W = $bits(liang_pkg::idToEx)
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                    flush;
    logic [ENQ_W-1:0]        enq_valid;
    logic [ENQ_W*DATA_W-1:0] enq_data;
    logic                    enq_ready;
    logic [DEQ_W-1:0]        deq_valid;
    logic [DEQ_W*DATA_W-1:0] deq_data;
    logic [DEQ_W-1:0]        deq_ready;
    logic [CW-1:0]           count;

    modport master (
        output flush, enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, count
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, count
    );
endinterface

// File: rtl/queue_ptr.sv
// Single flag+value ring pointer register with a 0..4 step per cycle.
module queue_ptr
    import utils::*;
#(
    parameter int unsigned VW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [2:0] inc,
    output ptr_t       ptr
);

    // Pointer register; clear has priority over the step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_add(ptr, inc, VW);
        end
    end

endmodule

// File: rtl/uop_queue.sv
// Multi-lane in-order micro-op queue between decode and execute.
module uop_queue
    import liang_pkg::*;
    import utils::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 1,
    parameter int unsigned DATA_W = $bits(idToEx)
) (
    input logic        clk,
    input logic        rst_n,
    uop_queue_if.slave q
);
    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - ENQ_W);

    ptr_t              head;
    ptr_t              tail;
    logic [CW-1:0]     occupancy;
    logic              enq_ok;
    logic [DEQ_W-1:0]  lane_valid;
    logic [2:0]        enq_num;
    logic [2:0]        deq_num;
    logic [DATA_W-1:0] mem [DEPTH];

    // Occupancy and acceptance depend only on registered pointers.
    assign occupancy = CW'(ptr_diff(tail, head, AW));
    assign enq_ok    = (occupancy <= ENQ_LIMIT);
    assign enq_num   = enq_ok ? pop4(4'(q.enq_valid)) : 3'd0;
    assign deq_num   = pop4(4'(lane_valid & q.deq_ready));

    // Dequeue lane j is valid when more than j entries are held.
    always_comb begin
        lane_valid = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            lane_valid[j] = (occupancy > CW'(j));
        end
    end

    // Payload storage; write each accepted lane at tail+i.
    always_ff @(posedge clk) begin
        if (enq_ok && !q.flush) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (q.enq_valid[i]) begin
                    mem[tail.value[AW-1:0] + AW'(i)] <= q.enq_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read lanes straight out of storage from head+j.
    for (genvar j = 0; j < DEQ_W; j++) begin : g_deq
        assign q.deq_data[j*DATA_W +: DATA_W] = mem[head.value[AW-1:0] + AW'(j)];
    end

    assign q.enq_ready = enq_ok;
    assign q.deq_valid = lane_valid;
    assign q.count     = occupancy;

    queue_ptr #(.VW(AW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (q.flush),
        .inc   (deq_num),
        .ptr   (head)
    );

    queue_ptr #(.VW(AW)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (q.flush),
        .inc   (enq_num),
        .ptr   (tail)
    );

    // Lane masks must be contiguous from lane 0.
    a_enq_contig : assert property (@(posedge clk) disable iff (!rst_n)
        ((q.enq_valid & (q.enq_valid + ENQ_W'(1))) == '0))
        else $error("uop_queue: non-contiguous enq_valid");

    a_deq_contig : assert property (@(posedge clk) disable iff (!rst_n)
        ((q.deq_ready & (q.deq_ready + DEQ_W'(1))) == '0))
        else $error("uop_queue: non-contiguous deq_ready");

endmodule

// File: tb/tb_uop_queue.sv
// Randomized self-checking bench for uop_queue against a queue-based model.
module tb_uop_queue;
    import liang_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ENQ_W  = 2;
    localparam int unsigned DEQ_W  = 1;
    localparam int unsigned DATA_W = $bits(idToEx);
    localparam int          SEQ_N  = 20;

    typedef logic [127:0]            val_t;
    typedef logic [DATA_W-1:0]       data_t;
    typedef logic [ENQ_W*DATA_W-1:0] lanes_t;
    typedef logic [ENQ_W-1:0]        en_t;
    typedef logic [DEQ_W-1:0]        dq_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    seq_exp = 0;
    bit    rec_en  = 1'b0;
    data_t model_q [$];

    uop_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W)) qif ();

    uop_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic data_t rand_data();
        return data_t'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic lanes_t rand_lanes();
        lanes_t l;
        for (int i = 0; i < ENQ_W; i++) l[i*DATA_W +: DATA_W] = rand_data();
        return l;
    endfunction

    // Apply one cycle of stimulus at a negedge, compare, then advance the model.
    task automatic drive(input en_t ev, input dq_t dr, input logic fl, input lanes_t ed);
        int   sz;
        int   acc;
        int   pops;
        logic exp_rdy;
        dq_t  exp_dv;
        qif.enq_valid = ev;
        qif.enq_data  = ed;
        qif.deq_ready = dr;
        qif.flush     = fl;
        #1;
        sz      = model_q.size();
        exp_rdy = (int'(DEPTH) - sz) >= int'(ENQ_W);
        for (int j = 0; j < DEQ_W; j++) exp_dv[j] = (sz > j);
        check("count", val_t'(qif.count), val_t'(sz));
        check("enq_ready", val_t'(qif.enq_ready), val_t'(exp_rdy));
        check("deq_valid", val_t'(qif.deq_valid), val_t'(exp_dv));
        for (int j = 0; j < DEQ_W; j++) begin
            if (j < sz) check("deq_data", val_t'(qif.deq_data[j*DATA_W +: DATA_W]), val_t'(model_q[j]));
        end
        pops = 0;
        for (int j = 0; j < DEQ_W; j++) begin
            if (dr[j] && j < sz) begin
                pops++;
                if (rec_en) begin
                    check("seq_order", val_t'(qif.deq_data[j*DATA_W +: DATA_W]), val_t'(seq_exp));
                    seq_exp++;
                end
            end
        end
        acc = 0;
        if (exp_rdy) for (int i = 0; i < ENQ_W; i++) acc += int'(ev[i]);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            repeat (pops) void'(model_q.pop_front());
            for (int i = 0; i < acc; i++) model_q.push_back(ed[i*DATA_W +: DATA_W]);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        data_t  a;
        data_t  b;
        lanes_t pk;
        int     seq_next;
        int     n;
        int     m;
        logic   rdy;

        rst_n         = 1'b0;
        qif.flush     = 1'b0;
        qif.enq_valid = '0;
        qif.enq_data  = '0;
        qif.deq_ready = '0;
        #12;
        check("rst_count", val_t'(qif.count), val_t'(0));
        check("rst_deq_valid", val_t'(qif.deq_valid), val_t'(0));
        check("rst_enq_ready", val_t'(qif.enq_ready), val_t'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two lanes in one cycle, drained one per cycle in order.
        a  = rand_data();
        b  = rand_data();
        pk = rand_lanes();
        pk[0 +: DATA_W]      = a;
        pk[DATA_W +: DATA_W] = b;
        drive(en_t'(3), dq_t'(0), 1'b0, pk);
        check("ab_count", val_t'(qif.count), val_t'(2));
        check("ab_first", val_t'(qif.deq_data[DATA_W-1:0]), val_t'(a));
        drive(en_t'(0), dq_t'(1), 1'b0, rand_lanes());
        check("ab_second", val_t'(qif.deq_data[DATA_W-1:0]), val_t'(b));
        drive(en_t'(0), dq_t'(1), 1'b0, rand_lanes());
        check("ab_empty_count", val_t'(qif.count), val_t'(0));
        check("ab_empty_valid", val_t'(qif.deq_valid), val_t'(0));

        // Fill thresholds and full behaviour.
        repeat (3) drive(en_t'(3), dq_t'(0), 1'b0, rand_lanes());
        check("c6_count", val_t'(qif.count), val_t'(6));
        check("c6_ready", val_t'(qif.enq_ready), val_t'(1));
        drive(en_t'(1), dq_t'(0), 1'b0, rand_lanes());
        qif.enq_valid = en_t'(3);
        qif.deq_ready = dq_t'(1);
        #1;
        check("c7_ready_with_deq", val_t'(qif.enq_ready), val_t'(0));
        drive(en_t'(3), dq_t'(1), 1'b0, rand_lanes());
        check("c7_no_enq", val_t'(qif.count), val_t'(6));
        drive(en_t'(3), dq_t'(0), 1'b0, rand_lanes());
        check("full_count", val_t'(qif.count), val_t'(DEPTH));
        check("full_ready", val_t'(qif.enq_ready), val_t'(0));
        check("full_valid", val_t'(qif.deq_valid), val_t'(1));
        drive(en_t'(3), dq_t'(1), 1'b0, rand_lanes());
        check("full_pop_count", val_t'(qif.count), val_t'(7));

        // Flush overrides concurrent enqueue and dequeue.
        repeat (2) drive(en_t'(0), dq_t'(1), 1'b0, rand_lanes());
        check("pre_flush_count", val_t'(qif.count), val_t'(5));
        drive(en_t'(3), dq_t'(1), 1'b1, rand_lanes());
        check("flush_count", val_t'(qif.count), val_t'(0));
        check("flush_valid", val_t'(qif.deq_valid), val_t'(0));
        check("flush_ready", val_t'(qif.enq_ready), val_t'(1));

        // Sequential values through the ring under random back-pressure.
        seq_next = 0;
        seq_exp  = 0;
        rec_en   = 1'b1;
        for (int cyc = 0; cyc < 400 && seq_exp < SEQ_N; cyc++) begin
            n = int'($urandom_range(0, ENQ_W));
            if (n > SEQ_N - seq_next) n = SEQ_N - seq_next;
            rdy = (int'(DEPTH) - model_q.size()) >= int'(ENQ_W);
            pk  = rand_lanes();
            for (int i = 0; i < n; i++) pk[i*DATA_W +: DATA_W] = data_t'(seq_next + i);
            drive(en_t'((1 << n) - 1), dq_t'($urandom_range(0, 1)), 1'b0, pk);
            if (rdy) seq_next += n;
        end
        rec_en = 1'b0;
        check("seq_received", val_t'(seq_exp), val_t'(SEQ_N));

        // Asynchronous reset mid-stream, then a fresh enqueue.
        drive(en_t'(0), dq_t'(0), 1'b1, rand_lanes());
        drive(en_t'(3), dq_t'(0), 1'b0, rand_lanes());
        drive(en_t'(1), dq_t'(0), 1'b0, rand_lanes());
        check("pre_rst_count", val_t'(qif.count), val_t'(3));
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", val_t'(qif.count), val_t'(0));
        check("mid_rst_valid", val_t'(qif.deq_valid), val_t'(0));
        check("mid_rst_ready", val_t'(qif.enq_ready), val_t'(1));
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a  = rand_data();
        pk = rand_lanes();
        pk[0 +: DATA_W] = a;
        drive(en_t'(1), dq_t'(0), 1'b0, pk);
        check("post_rst_data", val_t'(qif.deq_data[DATA_W-1:0]), val_t'(a));
        check("post_rst_count", val_t'(qif.count), val_t'(1));

        // Free-running random traffic with occasional flush.
        for (int cyc = 0; cyc < 300; cyc++) begin
            n = int'($urandom_range(0, ENQ_W));
            m = int'($urandom_range(0, DEQ_W));
            drive(en_t'((1 << n) - 1), dq_t'((1 << m) - 1), ($urandom_range(0, 15) == 0), rand_lanes());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
